// File: rtl/card_dealer_if.sv
// card_dealer_if: draw/shuffle handshake and dealt-card bus between the deck and the game logic.
interface card_dealer_if;
    logic       shuffle;
    logic       draw_req;
    logic       busy;
    logic       card_valid;
    logic [5:0] card_index;
    logic [3:0] card_rank;
    logic [1:0] card_suit;
    logic [3:0] card_value;
    logic [5:0] cards_left;
    logic       deck_empty;
    logic       draw_err;
    modport master (
        output shuffle, draw_req,
        input  busy, card_valid, card_index, card_rank, card_suit, card_value, cards_left, deck_empty, draw_err
    );
    modport slave (
        input  shuffle, draw_req,
        output busy, card_valid, card_index, card_rank, card_suit, card_value, cards_left, deck_empty, draw_err
    );
endinterface

// File: rtl/card_dealer.sv
// card_dealer: 52-card deck dealing one unique card per draw, LFSR start plus linear probe.
// Defining CARD_DEALER_FIXED_ORDER_EN replaces the LFSR start with a sequential pointer.
module card_dealer #(
    parameter logic [15:0] SEED = 16'h0539
) (
    input logic         clock_100Mhz,
    input logic         reset,
    card_dealer_if.slave bus
);
    typedef enum logic {IDLE, PROBE} state_t;
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    state_t      state;
    logic [51:0] dealt;
    logic [5:0]  probe;
    logic [5:0]  start;
    logic [15:0] lfsr;
    logic [1:0]  suit;
    logic [3:0]  rank;
    logic [3:0]  value;
`ifdef CARD_DEALER_FIXED_ORDER_EN
    logic [5:0]  ptr;
    assign start = ptr;
`else
    assign start = (lfsr[5:0] >= 6'd52) ? lfsr[5:0] - 6'd52 : lfsr[5:0];
`endif
    always_comb begin
        suit  = (probe >= 6'd39) ? 2'd3 : (probe >= 6'd26) ? 2'd2 : (probe >= 6'd13) ? 2'd1 : 2'd0;
        rank  = 4'(probe - 6'd13 * 6'(suit) + 6'd1);
        value = (rank == 4'd1) ? 4'd1 : (rank >= 4'd10) ? 4'd10 : rank;
    end
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            dealt          <= '0;
            probe          <= '0;
            lfsr           <= LFSR_INIT;
            bus.busy       <= 1'b0;
            bus.card_valid <= 1'b0;
            bus.draw_err   <= 1'b0;
            bus.deck_empty <= 1'b0;
            bus.cards_left <= 6'd52;
            bus.card_index <= '0;
            bus.card_rank  <= '0;
            bus.card_suit  <= '0;
            bus.card_value <= '0;
`ifdef CARD_DEALER_FIXED_ORDER_EN
            ptr            <= '0;
`endif
        end else begin
            lfsr           <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            bus.card_valid <= 1'b0;
            bus.draw_err   <= 1'b0;
            // shuffle overrides everything, including an in-flight search and a same-cycle draw
            if (bus.shuffle) begin
                state          <= IDLE;
                dealt          <= '0;
                bus.busy       <= 1'b0;
                bus.cards_left <= 6'd52;
                bus.deck_empty <= 1'b0;
`ifdef CARD_DEALER_FIXED_ORDER_EN
                ptr            <= '0;
`endif
            end else if (state == IDLE) begin
                if (bus.draw_req && bus.cards_left != 6'd0) begin
                    probe    <= start;
                    state    <= PROBE;
                    bus.busy <= 1'b1;
`ifdef CARD_DEALER_FIXED_ORDER_EN
                    ptr      <= (ptr == 6'd51) ? 6'd0 : ptr + 6'd1;
`endif
                end else if (bus.draw_req) begin
                    bus.draw_err <= 1'b1;
                end
            end else if (!dealt[probe]) begin
                dealt[probe]   <= 1'b1;
                bus.cards_left <= bus.cards_left - 6'd1;
                bus.deck_empty <= bus.cards_left == 6'd1;
                bus.card_index <= probe;
                bus.card_rank  <= rank;
                bus.card_suit  <= suit;
                bus.card_value <= value;
                bus.card_valid <= 1'b1;
                bus.busy       <= 1'b0;
                state          <= IDLE;
            end else begin
                probe <= (probe == 6'd51) ? 6'd0 : probe + 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: scoreboard bench predicting every dealt card and its latency from a deck model.
// Honours CARD_DEALER_FIXED_ORDER_EN the same way as the design.
module tb_card_dealer;
    logic clock_100Mhz = 1'b0;
    logic reset;
    card_dealer_if dif();
    card_dealer #(.SEED(16'h0539)) dut (
        .clock_100Mhz(clock_100Mhz),
        .reset(reset),
        .bus(dif.slave)
    );
    always #5 clock_100Mhz = ~clock_100Mhz;

    typedef struct {int idx; int lat;} exp_t;
    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          m_left;
    int          last_idx;
    logic [51:0] m_dealt;
    logic [51:0] seen;
    logic [15:0] m_lfsr;
`ifdef CARD_DEALER_FIXED_ORDER_EN
    int          m_ptr;
`endif

    always @(posedge clock_100Mhz or posedge reset)
        if (reset) m_lfsr <= 16'h0539;
        else m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock_100Mhz);
        #1;
    endtask

    task automatic model_clear;
        m_dealt = '0;
        seen = '0;
        m_left = 52;
`ifdef CARD_DEALER_FIXED_ORDER_EN
        m_ptr = 0;
`endif
    endtask

    task automatic draw(input bit poke_busy);
        int start, i, skips, lat, rank;
        bit got;
        exp_t e;
`ifdef CARD_DEALER_FIXED_ORDER_EN
        start = m_ptr;
        m_ptr = (m_ptr == 51) ? 0 : m_ptr + 1;
`else
        start = int'(m_lfsr[5:0]);
        if (start >= 52) start -= 52;
`endif
        i = start;
        skips = 0;
        while (m_dealt[i]) begin
            i = (i == 51) ? 0 : i + 1;
            skips++;
        end
        m_dealt[i] = 1'b1;
        m_left--;
        e.idx = i;
        e.lat = skips + 2;
        sb.push_back(e);
        dif.draw_req = 1'b1;
        tick();
        dif.draw_req = 1'b0;
        lat = 1;
        check("busy_on", dif.busy, 1);
        if (poke_busy) dif.draw_req = 1'b1;
        got = 1'b0;
        while (!got && lat < 60) begin
            tick();
            dif.draw_req = 1'b0;
            lat++;
            got = dif.card_valid;
        end
        if (!got) begin
            check("draw_timeout", 0, 1);
            sb.delete();
        end else begin
            e = sb.pop_front();
            rank = e.idx % 13 + 1;
            check("card_index", dif.card_index, e.idx);
            check("card_rank", dif.card_rank, rank);
            check("card_suit", dif.card_suit, e.idx / 13);
            check("card_value", dif.card_value, (rank == 1) ? 1 : (rank > 9) ? 10 : rank);
            check("latency", lat, e.lat);
            check("unique", seen[dif.card_index], 0);
            check("cards_left", dif.cards_left, m_left);
            check("deck_empty", dif.deck_empty, m_left == 0);
            seen[dif.card_index] = 1'b1;
            last_idx = e.idx;
        end
        tick();
        check("valid_pulse", dif.card_valid, 0);
        check("busy_off", dif.busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        dif.shuffle = 1'b0;
        dif.draw_req = 1'b0;
        model_clear();
        last_idx = 0;
        repeat (3) tick();
        check("rst_cards_left", dif.cards_left, 52);
        check("rst_busy", dif.busy, 0);
        check("rst_valid", dif.card_valid, 0);
        check("rst_empty", dif.deck_empty, 0);
        check("rst_index", dif.card_index, 0);
        check("rst_value", dif.card_value, 0);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("idle_cards_left", dif.cards_left, 52);
            check("idle_empty", dif.deck_empty, 0);
            check("idle_busy", dif.busy, 0);
            check("idle_valid", dif.card_valid, 0);
        end
        for (int k = 0; k < 52; k++) draw(k % 3 == 1);
        check("full_empty", dif.deck_empty, 1);
        check("full_left", dif.cards_left, 0);
        dif.draw_req = 1'b1;
        tick();
        dif.draw_req = 1'b0;
        check("empty_err", dif.draw_err, 1);
        check("empty_busy", dif.busy, 0);
        tick();
        check("err_pulse", dif.draw_err, 0);
        check("empty_no_valid", dif.card_valid, 0);
        // empty deck: a draw that slipped past shuffle would raise draw_err
        dif.shuffle = 1'b1;
        dif.draw_req = 1'b1;
        tick();
        dif.shuffle = 1'b0;
        dif.draw_req = 1'b0;
        model_clear();
        check("shdraw_err", dif.draw_err, 0);
        check("shdraw_busy", dif.busy, 0);
        check("shdraw_left", dif.cards_left, 52);
        check("shdraw_empty", dif.deck_empty, 0);
        tick();
        check("shdraw_valid", dif.card_valid, 0);
        check("shdraw_busy2", dif.busy, 0);
        for (int k = 0; k < 51; k++) draw(1'b0);
        check("left_one", dif.cards_left, 1);
        dif.draw_req = 1'b1;
        tick();
        dif.draw_req = 1'b0;
        check("abort_busy_on", dif.busy, 1);
        dif.shuffle = 1'b1;
        tick();
        dif.shuffle = 1'b0;
        model_clear();
        check("abort_busy", dif.busy, 0);
        check("abort_valid", dif.card_valid, 0);
        check("abort_left", dif.cards_left, 52);
        check("abort_hold_idx", dif.card_index, last_idx);
        tick();
        check("abort_valid2", dif.card_valid, 0);
        for (int k = 0; k < 3; k++) draw(1'b0);
        dif.draw_req = 1'b1;
        tick();
        dif.draw_req = 1'b0;
        check("mid_busy_on", dif.busy, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", dif.busy, 0);
        check("arst_valid", dif.card_valid, 0);
        check("arst_left", dif.cards_left, 52);
        check("arst_index", dif.card_index, 0);
        model_clear();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) draw(1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
